// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter. The arbiter takes the slave
// modport; the requesters plus the byte transmitter sit on the master side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic [7:0]           tx_data_byte;
    logic                 tx_send_en;
    logic                 tx_done;
    logic                 timeout_err;

    modport master (
        output req, req_data, tx_done,
        input  grant, done, busy, tx_data_byte, tx_send_en, timeout_err
    );

    modport slave (
        input  req, req_data, tx_done,
        output grant, done, busy, tx_data_byte, tx_send_en, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART byte transmitter among NUM_REQ requesters, with an
// idle gap between bytes. Define UART_ARB_TIMEOUT_EN to add the stuck-transmitter watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int              PW       = $clog2(NUM_REQ);
    localparam logic [PW:0]     NR       = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0]   LAST_IDX = PW'(NUM_REQ - 1);
    localparam logic [15:0]     GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_GAP} state_t;

    state_t                   r_state;
    logic [PW-1:0]            r_ptr;
    logic [PW-1:0]            r_win;
    logic [NUM_REQ-1:0]       r_grant;
    logic [NUM_REQ-1:0]       r_done;
    logic                     r_busy;
    logic                     r_send;
    logic [7:0]               r_data;
    logic [15:0]              r_gap_cnt;

    logic [NUM_REQ-1:0][7:0]  w_bytes;
    logic                     w_found;
    logic [PW-1:0]            w_sel;
    logic [PW:0]              w_idx;
    logic [PW-1:0]            w_ptr_nxt;
    logic                     w_tx_ok;
    logic                     w_expired;
    logic                     w_finish;

    assign w_bytes   = bus.req_data;
    assign w_ptr_nxt = (r_win == LAST_IDX) ? '0 : r_win + 1'b1;
    // tx_done during the issue cycle (send_en still high) cannot be a real completion
    assign w_tx_ok   = bus.tx_done && !r_send;
    assign w_finish  = (r_state == S_WAIT_DONE) && (w_tx_ok || w_expired);

    // First requester at or after r_ptr, wrapping explicitly modulo NUM_REQ
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_idx >= NR) w_idx = w_idx - NR;
            if (!w_found && bus.req[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[PW-1:0];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
    logic [23:0] r_wdog;
    logic        r_tmo;
    assign w_expired       = (r_wdog == TMO_LAST);
    assign bus.timeout_err = r_tmo;
`else
    assign w_expired       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_send    <= 1'b0;
            r_data    <= 8'h00;
            r_gap_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_wdog    <= '0;
            r_tmo     <= 1'b0;
`endif
        end else begin
            r_grant <= '0;
            r_done  <= '0;
            r_send  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_tmo   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_WAIT_DONE;
                        r_grant <= NUM_REQ'(1) << w_sel;
                        r_send  <= 1'b1;
                        r_data  <= w_bytes[w_sel];
                        r_win   <= w_sel;
                        r_busy  <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                        r_wdog  <= '0;
`endif
                    end
                end
                S_WAIT_DONE: begin
`ifdef UART_ARB_TIMEOUT_EN
                    r_wdog <= r_wdog + 1'b1;
`endif
                    if (w_finish) begin
                        // a real tx_done outranks a simultaneous watchdog expiry
                        r_done    <= w_tx_ok ? (NUM_REQ'(1) << r_win) : '0;
`ifdef UART_ARB_TIMEOUT_EN
                        r_tmo     <= !w_tx_ok;
`endif
                        r_ptr     <= w_ptr_nxt;
                        r_gap_cnt <= '0;
                        if (GAP_CYCLES > 0) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant        = r_grant;
    assign bus.done         = r_done;
    assign bus.busy         = r_busy;
    assign bus.tx_data_byte = r_data;
    assign bus.tx_send_en   = r_send;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scenario tasks checked against a transaction-level
// round-robin model (pointer + expected event cycle offsets).
module tb_uart_tx_arbiter;
    localparam int NR  = 4;
    localparam int GAP = 16;
    localparam int TMO = 1000;
    localparam int IW  = $clog2(NR);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

    uart_tx_arbiter #(
        .NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int     checks = 0;
    int     errors = 0;
    int     m_ptr  = 0;
    longint cyc    = 0;
    longint last_issue = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pick(input logic [NR-1:0] r, input int p);
        logic [NR-1:0] t;
        for (int o = 0; o < NR; o++) begin
            t = r >> ((p + o) % NR);
            if (t[0]) return (p + o) % NR;
        end
        return -1;
    endfunction

    // One byte from IDLE: grant 1 cycle after req, tx_done sampled k edges after
    // the issue edge, done on that edge, busy low GAP edges later.
    task automatic xfer(input logic [NR-1:0] rq, input logic [8*NR-1:0] d, input int k,
                        input bit keep_req, input bit early, input int spacing);
        int w;
        logic [IW-1:0] wi;
        logic [NR-1:0] oh;
        logic [NR-1:0][7:0] bytes;
        logic [7:0] eb;
        w  = pick(rq, m_ptr);
        wi = w[IW-1:0];
        oh = NR'(1) << w;
        bytes = d;
        eb = bytes[wi];
        bus.req = rq;
        bus.req_data = d;
        @(negedge clk);
        checks++;
        if (bus.grant !== oh || bus.tx_send_en !== 1'b1 || bus.tx_data_byte !== eb || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL issue: grant=%b send=%b byte=%h busy=%b want grant=%b send=1 byte=%h busy=1",
                     bus.grant, bus.tx_send_en, bus.tx_data_byte, bus.busy, oh, eb);
        end
        if (spacing > 0) begin
            checks++;
            if (cyc - last_issue != longint'(spacing)) begin
                errors++;
                $display("FAIL spacing: got %0d want %0d", cyc - last_issue, spacing);
            end
        end
        last_issue = cyc;
        if (!keep_req) bus.req = '0;
        bus.req_data = d ^ {NR{8'hC3}};
        for (int i = 1; i < k; i++) begin
            bus.tx_done = early && (i == 1);
            @(negedge clk);
            bus.tx_done = 1'b0;
            checks++;
            if (bus.tx_data_byte !== eb || bus.grant !== '0 || bus.tx_send_en !== 1'b0 ||
                bus.done !== '0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL wait[%0d]: byte=%h grant=%b send=%b done=%b busy=%b want byte=%h rest idle, busy=1",
                         i, bus.tx_data_byte, bus.grant, bus.tx_send_en, bus.done, bus.busy, eb);
            end
        end
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        checks++;
        if (bus.done !== oh || bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL done: done=%b busy=%b tmo=%b want done=%b busy=1 tmo=0",
                     bus.done, bus.busy, bus.timeout_err, oh);
        end
        m_ptr = (w + 1) % NR;
        repeat (GAP - 1) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== '0 || bus.grant !== '0) begin
                errors++;
                $display("FAIL gap: busy=%b done=%b grant=%b want 1/0/0", bus.busy, bus.done, bus.grant);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.grant !== '0) begin
            errors++;
            $display("FAIL gap_end: busy=%b grant=%b want 0/0", bus.busy, bus.grant);
        end
    endtask

    task automatic test_reset();
        bus.req = '1;
        bus.req_data = 32'h44332211;
        bus.tx_done = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.grant !== '0 || bus.done !== '0 || bus.busy !== 1'b0 || bus.tx_send_en !== 1'b0 ||
                bus.tx_data_byte !== 8'h00 || bus.timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL reset: g=%b d=%b busy=%b s=%b b=%h t=%b want all 0",
                         bus.grant, bus.done, bus.busy, bus.tx_send_en, bus.tx_data_byte, bus.timeout_err);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0001 || bus.tx_send_en !== 1'b1 || bus.tx_data_byte !== 8'h11) begin
            errors++;
            $display("FAIL first_grant: grant=%b send=%b byte=%h want 0001/1/11",
                     bus.grant, bus.tx_send_en, bus.tx_data_byte);
        end
        // reset mid-transfer abandons the byte with no done
        bus.req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        checks++;
        if (bus.done !== '0 || bus.busy !== 1'b0 || bus.grant !== '0) begin
            errors++;
            $display("FAIL reset_abandon: done=%b busy=%b grant=%b want 0/0/0", bus.done, bus.busy, bus.grant);
        end
        m_ptr = 0;
    endtask

    task automatic test_round_robin();
        for (int n = 0; n < 5; n++)
            xfer(4'b1111, 32'hD4C3B2A1, 50, n != 4, 1'b0, (n == 0) ? 0 : 50 + 1 + GAP);
    endtask

    task automatic test_single();
        xfer(4'b0100, 32'h00A50000, 200, 1'b0, 1'b0, 0);
    endtask

    task automatic test_wrap();
        xfer(4'b0100, 32'h0000_5500, 10, 1'b0, 1'b0, 0);
        xfer(4'b0011, 32'h0000_2211, 10, 1'b0, 1'b0, 0);
        xfer(4'b0011, 32'h0000_2211, 10, 1'b0, 1'b0, 0);
    endtask

    task automatic test_stability_and_stray();
        xfer(4'b0001, 32'h0000_003C, 30, 1'b0, 1'b1, 0);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.done !== '0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL stray_done: done=%b busy=%b want 0/0", bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] rq;
        int k;
        for (int n = 0; n < 20; n++) begin
            rq = NR'($urandom_range(1, (1 << NR) - 1));
            k  = $urandom_range(2, 40);
            xfer(rq, $urandom, k, 1'b0, (k >= 3) && ($urandom_range(0, 1) == 1), 0);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit bad;
        bus.req = 4'b0010;
        bus.req_data = 32'h0000_7700;
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0010 || bus.tx_send_en !== 1'b1) begin
            errors++;
            $display("FAIL tmo_grant: grant=%b send=%b want 0010/1", bus.grant, bus.tx_send_en);
        end
        bus.req = 4'b0101;
        n = 0;
        bad = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        while (n < 3 * TMO && bus.timeout_err !== 1'b1) begin
            @(negedge clk);
            n++;
            if (bus.done !== '0) bad = 1'b1;
        end
        checks++;
        if (n != TMO || bad) begin
            errors++;
            $display("FAIL timeout: err after %0d cycles (done seen=%0d) want %0d, no done", n, bad, TMO);
        end
        m_ptr = 2;
        repeat (GAP) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_gap: busy=%b tmo=%b want 0/0", bus.busy, bus.timeout_err);
        end
`else
        repeat (5000) begin
            @(negedge clk);
            n++;
            if (bus.done !== '0 || bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_watchdog: left WAIT_DONE within %0d cycles", n);
        end
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        checks++;
        if (bus.done !== 4'b0010) begin
            errors++;
            $display("FAIL late_done: done=%b want 0010", bus.done);
        end
        m_ptr = 2;
        repeat (GAP) @(negedge clk);
`endif
        xfer(4'b0101, 32'h0066_0055, 5, 1'b0, 1'b0, 0);
    endtask

    initial begin
        bus.req = '0;
        bus.req_data = '0;
        bus.tx_done = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_stability_and_stray();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
